scoreboard_display_seq: RTL and testbench
=========================================

# scoreboard_display_seq

Display sequencer for the scoreboard's two-digit 7-segment output stage. It alternates between player A and player B. Each player gets a label phase, showing "P1" or "P2", followed by a score phase showing the binary score converted to two BCD digit codes. Its `tens_o`/`ones_o` codes feed the dual-digit BCD-to-7-segment encoder directly. Codes 10 (blank), 11 ('P') and 15 (dash, error) are encoder-defined glyphs.

## Interface
Parameters:
- `TICK_DIV`, default 1000: clock cycles per display tick (≥2).
- `LABEL_TICKS`, default 2: ticks a label ("P1"/"P2") is shown (≥1).
- `SCORE_TICKS`, default 6: ticks a score is shown (≥1).

Ports:
- `clk_i`  in  1: clock. One clock domain; all logic on rising edge.
- `rst_ni`  in  1: reset. Synchronous, active-low.
- `enable_i`  in  1: 1 = run the sequence; 0 = blank display, return to IDLE.
- `hold_i`  in  1: 1 = freeze the tick prescaler (display phase extended).
- `score_a_i`  in  7: player A score, binary, valid range 0–99.
- `score_b_i`  in  7: player B score, binary, valid range 0–99.
- `tens_o`  out  4: tens digit code to the encoder. Registered.
- `ones_o`  out  4: ones digit code to the encoder. Registered.
- `phase_o`  out  2: 0 = idle, 1 = player A active, 2 = player B active. Registered.

## Operation
- **States:** IDLE, LABEL_A, CONV_A, SHOW_A, LABEL_B, CONV_B, SHOW_B. The state register and all outputs update on the same edge.
- **Reset** (`rst_ni` = 0 at an edge):
  - State → IDLE; `tens_o` = 10, `ones_o` = 10, `phase_o` = 0.
  - Prescaler, tick counter and conversion registers cleared.
  - Reset overrides everything, including mid-conversion.
- **IDLE:** outputs 10/10, phase 0. On an edge with `enable_i` = 1: → LABEL_A, outputs 11/1, phase 1.
- **`enable_i` = 0 in any non-IDLE state:** next edge → IDLE with outputs 10/10, phase 0. `enable_i` has priority over `hold_i` and over all state transitions.
- **LABEL_x:**
  - Outputs 11/1 for A, 11/2 for B.
  - Lasts LABEL_TICKS ticks, then → CONV_x.
  - On that edge: capture `rem` ← `score_x_i` (7 bit) and `tacc` ← 0 (4 bit).
- **CONV_x** (repeated subtraction; outputs hold the label values):
  - Each cycle while `rem` ≥ 10 and `rem` ≤ 99: `rem` ← `rem` − 10, `tacc` ← `tacc` + 1.
  - If `rem` < 10: → SHOW_x. `ones_o` ← `rem`. `tens_o` ← 10 if `tacc` = 0 (leading-zero blanking), else `tacc`.
  - If the captured value is > 99 (checked in the first CONV cycle): → SHOW_x with outputs 15/15.
  - Duration: floor(v/10) + 1 cycles for v ≤ 99; 1 cycle for v > 99.
  - Score inputs are ignored after capture.
- **SHOW_x:** lasts SCORE_TICKS ticks. SHOW_A → LABEL_B (11/2, phase 2); SHOW_B → LABEL_A (11/1, phase 1).
- **Tick generation:**
  - The prescaler counts 0..TICK_DIV−1; a tick is the cycle where it equals TICK_DIV−1.
  - The tick counter counts ticks within a LABEL/SHOW state.
  - Both are cleared on entry to every LABEL/SHOW state and stay idle in CONV/IDLE.
- **`hold_i` = 1:** prescaler does not advance and no tick occurs. CONV still runs to completion. No effect in IDLE.

## Timing
- Enable to first label: 1 cycle (edge sampling `enable_i` = 1 in IDLE drives 11/1).
- Each LABEL_x state lasts exactly LABEL_TICKS·TICK_DIV cycles plus the number of held cycles.
- Each SHOW_x state lasts exactly SCORE_TICKS·TICK_DIV cycles plus the number of held cycles.
- Score to display latency from the end of the label: floor(v/10) + 1 cycles.
- Full period with no hold: 2·(LABEL_TICKS + SCORE_TICKS)·TICK_DIV + CONV_A + CONV_B cycles.
- Output codes never take values 12–14. Outputs change only on state-transition edges.

## Test plan
All scenarios use TICK_DIV = 4, LABEL_TICKS = 2, SCORE_TICKS = 3.
1. **Reset.** Hold `rst_ni` = 0 for 3 cycles, `enable_i` = 1 → 10/10, phase 0. First edge after release gives 11/1, phase 1.
2. **Nominal score A.** `score_a_i` = 47:
   - 11/1 for 8 cycles.
   - 11/1 held for 5 CONV cycles.
   - 4/7 for 12 cycles.
   - Then 11/2, phase 2.
3. **Boundary scores.**
   - `score_b_i` = 5 → 10/5.
   - `score_b_i` = 0 → 10/0 after a 1-cycle CONV.
   - `score_b_i` = 99 → 9/9 after a 10-cycle CONV.
   - `score_b_i` = 120 → 15/15 after a 1-cycle CONV.
4. **Score change mid-sequence.** Change `score_a_i` from 12 to 34 during CONV_A → shows 1/2. The next A cycle shows 3/4.
5. **Enable drop and restart.** Drop `enable_i` mid SHOW_B → 10/10, phase 0, next cycle. Re-assert → 11/1 one cycle later, with the full 8-cycle label duration.
6. **Hold and reset mid-conversion.**
   - `hold_i` = 1 for 7 cycles inside SHOW_A → SHOW_A lasts 19 cycles.
   - `rst_ni` = 0 during CONV_B → 10/10, phase 0, on that edge.

Source files
------------

// File: rtl/scoreboard_display_seq.sv
// Two-digit display sequencer: alternates "P1"/score A and "P2"/score B, converting
// each captured binary score to BCD digit codes by repeated subtraction.
module scoreboard_display_seq #(
    parameter int TICK_DIV    = 1000,
    parameter int LABEL_TICKS = 2,
    parameter int SCORE_TICKS = 6
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       hold_i,
    input  logic [6:0] score_a_i,
    input  logic [6:0] score_b_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic [1:0] phase_o
);

    localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_TICKS = (LABEL_TICKS > SCORE_TICKS) ? LABEL_TICKS : SCORE_TICKS;
    localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_P     = 4'd11;
    localparam logic [3:0] CODE_DASH  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LABEL_A,
        S_CONV_A,
        S_SHOW_A,
        S_LABEL_B,
        S_CONV_B,
        S_SHOW_B
    } state_t;

    state_t          r_state, w_state;
    logic [PW-1:0]   r_presc, w_presc;
    logic [TW-1:0]   r_ticks, w_ticks;
    logic [6:0]      r_rem,   w_rem;
    logic [3:0]      r_tacc,  w_tacc;
    logic [3:0]      r_tens,  w_tens;
    logic [3:0]      r_ones,  w_ones;
    logic [1:0]      r_phase, w_phase;
    logic            w_tick, w_timed, w_label_done, w_show_done;
    state_t          w_show_state;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_state      = r_state;
        w_presc      = r_presc;
        w_ticks      = r_ticks;
        w_rem        = r_rem;
        w_tacc       = r_tacc;
        w_tens       = r_tens;
        w_ones       = r_ones;
        w_phase      = r_phase;
        w_show_state = (r_state == S_CONV_A) ? S_SHOW_A : S_SHOW_B;

        w_timed      = r_state inside {S_LABEL_A, S_SHOW_A, S_LABEL_B, S_SHOW_B};
        w_tick       = w_timed && !hold_i && (r_presc == PW'(TICK_DIV - 1));
        w_label_done = w_tick && (r_ticks == TW'(LABEL_TICKS - 1));
        w_show_done  = w_tick && (r_ticks == TW'(SCORE_TICKS - 1));

        if (w_timed && !hold_i) begin
            w_presc = w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) w_ticks = r_ticks + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (enable_i) begin
                    w_state = S_LABEL_A;
                    w_presc = '0;
                    w_ticks = '0;
                    w_tens  = CODE_P;
                    w_ones  = 4'd1;
                    w_phase = 2'd1;
                end
            end
            S_LABEL_A, S_LABEL_B: begin
                if (w_label_done) begin
                    w_state = (r_state == S_LABEL_A) ? S_CONV_A : S_CONV_B;
                    w_rem   = (r_state == S_LABEL_A) ? score_a_i : score_b_i;
                    w_tacc  = '0;
                end
            end
            S_CONV_A, S_CONV_B: begin
                // rem only shrinks after capture, so this test is decisive on the first cycle.
                if (r_rem > 7'd99) begin
                    w_state = w_show_state;
                    w_presc = '0;
                    w_ticks = '0;
                    w_tens  = CODE_DASH;
                    w_ones  = CODE_DASH;
                end else if (r_rem >= 7'd10) begin
                    w_rem  = r_rem - 7'd10;
                    w_tacc = r_tacc + 1'b1;
                end else begin
                    w_state = w_show_state;
                    w_presc = '0;
                    w_ticks = '0;
                    w_tens  = (r_tacc == 4'd0) ? CODE_BLANK : r_tacc;
                    w_ones  = r_rem[3:0];
                end
            end
            S_SHOW_A, S_SHOW_B: begin
                if (w_show_done) begin
                    w_state = (r_state == S_SHOW_A) ? S_LABEL_B : S_LABEL_A;
                    w_presc = '0;
                    w_ticks = '0;
                    w_tens  = CODE_P;
                    w_ones  = (r_state == S_SHOW_A) ? 4'd2 : 4'd1;
                    w_phase = (r_state == S_SHOW_A) ? 2'd2 : 2'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Disable wins over hold and over every transition above.
        if (r_state != S_IDLE && !enable_i) begin
            w_state = S_IDLE;
            w_presc = '0;
            w_ticks = '0;
            w_tens  = CODE_BLANK;
            w_ones  = CODE_BLANK;
            w_phase = 2'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_ticks <= '0;
            r_rem   <= '0;
            r_tacc  <= '0;
            r_tens  <= CODE_BLANK;
            r_ones  <= CODE_BLANK;
            r_phase <= 2'd0;
        end else begin
            r_state <= w_state;
            r_presc <= w_presc;
            r_ticks <= w_ticks;
            r_rem   <= w_rem;
            r_tacc  <= w_tacc;
            r_tens  <= w_tens;
            r_ones  <= w_ones;
            r_phase <= w_phase;
        end
    end

    assign tens_o  = r_tens;
    assign ones_o  = r_ones;
    assign phase_o = r_phase;

endmodule

// File: tb/tb_scoreboard_display_seq.sv
// Scoreboard bench: stimulus queues expected display segments (codes, phase, length);
// a monitor pops one each time the outputs change and checks value and duration.
module tb_scoreboard_display_seq;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       enable_i;
    logic       hold_i;
    logic [6:0] score_a_i;
    logic [6:0] score_b_i;
    logic [3:0] tens_o;
    logic [3:0] ones_o;
    logic [1:0] phase_o;

    always #5 clk = ~clk;

    scoreboard_display_seq #(
        .TICK_DIV    (4),
        .LABEL_TICKS (2),
        .SCORE_TICKS (3)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .enable_i  (enable_i),
        .hold_i    (hold_i),
        .score_a_i (score_a_i),
        .score_b_i (score_b_i),
        .tens_o    (tens_o),
        .ones_o    (ones_o),
        .phase_o   (phase_o)
    );

    typedef struct {
        logic [3:0] tens;
        logic [3:0] ones;
        logic [1:0] phase;
        int         len;   // cycles the segment is displayed; 0 = not checked
    } seg_t;

    seg_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [3:0] t, input logic [3:0] o, input logic [1:0] p, input int len);
        seg_t s;
        s.tens  = t;
        s.ones  = o;
        s.phase = p;
        s.len   = len;
        exp_q.push_back(s);
    endtask

    // Returns 1 ns after the n-th rising edge (cyc == n).
    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        logic [9:0] cur;
        logic [9:0] prev;
        logic       have_prev;
        int         run;
        int         seg_idx;
        seg_t       cur_exp;
        have_prev   = 1'b0;
        run         = 0;
        seg_idx     = 0;
        cur_exp.len = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cur = {tens_o, ones_o, phase_o};
            if (!have_prev || cur !== prev) begin
                if (have_prev && cur_exp.len != 0)
                    check($sformatf("seg%0d_len", seg_idx), run, cur_exp.len);
                seg_idx++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL seg%0d_unexpected: got %0d/%0d phase %0d, required no change",
                             seg_idx, tens_o, ones_o, phase_o);
                    cur_exp.len = 0;
                end else begin
                    cur_exp = exp_q.pop_front();
                    check($sformatf("seg%0d_tens", seg_idx), tens_o, cur_exp.tens);
                    check($sformatf("seg%0d_ones", seg_idx), ones_o, cur_exp.ones);
                    check($sformatf("seg%0d_phase", seg_idx), phase_o, cur_exp.phase);
                end
                prev      = cur;
                have_prev = 1'b1;
                run       = 1;
            end else begin
                run++;
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL timeout: simulation did not finish, required finish by cycle 240");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_ni    = 1'b0;
        enable_i  = 1'b1;
        hold_i    = 1'b0;
        score_a_i = 7'd47;
        score_b_i = 7'd5;
        push(4'd10, 4'd10, 2'd0, 3);   // reset held 3 edges
        push(4'd11, 4'd1,  2'd1, 13);  // label 8 + conv(47) 5
        push(4'd4,  4'd7,  2'd1, 12);
        push(4'd11, 4'd2,  2'd2, 9);   // label 8 + conv(5) 1
        push(4'd10, 4'd5,  2'd2, 12);  // leading-zero blanking

        wait_until(3);
        rst_ni = 1'b1;

        wait_until(40);
        score_a_i = 7'd12;
        score_b_i = 7'd0;
        push(4'd11, 4'd1,  2'd1, 10);  // conv(12) 2
        push(4'd1,  4'd2,  2'd1, 12);
        push(4'd11, 4'd2,  2'd2, 9);   // conv(0) 1
        push(4'd10, 4'd0,  2'd2, 12);

        wait_until(58);                // CONV_A in progress: change must be ignored
        score_a_i = 7'd34;
        push(4'd11, 4'd1,  2'd1, 12);  // conv(34) 4
        push(4'd3,  4'd4,  2'd1, 19);  // 12 + 7 held cycles

        wait_until(85);
        score_b_i = 7'd99;
        push(4'd11, 4'd2,  2'd2, 18);  // conv(99) 10
        push(4'd9,  4'd9,  2'd2, 12);

        wait_until(107);
        hold_i = 1'b1;
        wait_until(110);
        score_a_i = 7'd8;
        wait_until(114);
        hold_i = 1'b0;
        push(4'd11, 4'd1,  2'd1, 9);
        push(4'd10, 4'd8,  2'd1, 12);

        wait_until(140);
        score_b_i = 7'd120;
        push(4'd11, 4'd2,  2'd2, 9);   // out-of-range: 1-cycle conv
        push(4'd15, 4'd15, 2'd2, 6);   // cut short by enable drop

        wait_until(189);
        enable_i  = 1'b0;
        score_a_i = 7'd90;
        push(4'd10, 4'd10, 2'd0, 3);
        push(4'd11, 4'd1,  2'd1, 18);  // full 8-cycle label + conv(90) 10
        push(4'd9,  4'd0,  2'd1, 12);

        wait_until(192);
        enable_i = 1'b1;

        wait_until(205);
        score_b_i = 7'd63;
        push(4'd11, 4'd2,  2'd2, 11);  // reset lands on 3rd conv cycle
        push(4'd10, 4'd10, 2'd0, 0);

        wait_until(233);
        rst_ni = 1'b0;
        wait_until(235);
        rst_ni   = 1'b1;
        enable_i = 1'b0;

        wait_until(240);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
